// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with level count, programmable almost-full /
// almost-empty thresholds, synchronous flush and an optional
// first-word-fall-through read port. At default parameters it reproduces the
// legacy 16x8 synchronous FIFO interface and flag timing.
module fifo_sync_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter bit FWFT       = 1'b0,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_THRESH);

    // Reject illegal parameter combinations at elaboration
    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("fifo_sync_param: FIFO_DEPTH must be >= 2");
    end
    if (!(AE_THRESH >= 1 && AE_THRESH < AF_THRESH && AF_THRESH <= FIFO_DEPTH - 1)) begin : g_bad_thresh
        $error("fifo_sync_param: thresholds must satisfy 1 <= AE_THRESH < AF_THRESH <= FIFO_DEPTH-1");
    end

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_ack_q, wr_ack_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic full_w, empty_w;
    logic wr_go, rd_go;

    // Pointer advance with an explicit wrap so any depth works, not just powers of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign full_w  = (count_q == CNT_FULL);
    assign empty_w = (count_q == '0);

    // A write into a full FIFO, or a read from an empty one, is simply dropped;
    // this alone gives "write only" on empty and "read only" on full.
    assign wr_go = wr_en & ~full_w;
    assign rd_go = rd_en & ~empty_w;

    // Next-state for pointers, occupancy and the one-cycle-late status bits; flush wins
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wr_ack_d    = wr_go;
        overflow_d  = wr_en & full_w;
        underflow_d = rd_en & empty_w;
        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            wr_ack_d    = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_go) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_go) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({wr_go, rd_go})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array: not reset, written only on an accepted, non-flushed write
    always_ff @(posedge clk) begin
        if (wr_go && !clr) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    if (!FWFT) begin : g_reg_read
        logic [FIFO_WIDTH-1:0] dout_q, dout_d;

        // Registered read port: load the head word on an accepted read, hold otherwise
        always_comb begin
            dout_d = dout_q;
            if (clr) begin
                dout_d = '0;
            end else if (rd_go) begin
                dout_d = mem[rd_ptr_q];
            end
        end

        // Read data register, cleared by reset
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q <= '0;
            end else begin
                dout_q <= dout_d;
            end
        end

        assign data_out = dout_q;
    end else begin : g_fwft_read
        // Head word is presented as soon as the FIFO is non-empty; rd_en pops it
        assign data_out = empty_w ? '0 : mem[rd_ptr_q];
    end

    assign wr_ack      = wr_ack_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign full        = full_w;
    assign empty       = empty_w;
    assign almostfull  = (count_q >= CNT_AF) && (count_q < CNT_FULL);
    assign almostempty = (count_q != '0) && (count_q <= CNT_AE);
    assign count       = count_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: default 16x8 registered-read FIFO,
// a depth-6 instance for non-power-of-two wrap, and an FWFT instance.
// All three share the stimulus; each section checks only the instance it targets.
module tb_fifo_sync_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] data_in = '0;

    logic [15:0] d8_dout, d6_dout, fw_dout;
    logic        d8_ack, d8_ovf, d8_udf, d8_full, d8_empty, d8_af, d8_ae;
    logic        d6_ack, d6_ovf, d6_udf, d6_full, d6_empty, d6_af, d6_ae;
    logic        fw_ack, fw_ovf, fw_udf, fw_full, fw_empty, fw_af, fw_ae;
    logic [3:0]  d8_cnt, fw_cnt;
    logic [2:0]  d6_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_sync_param u_d8 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .data_out(d8_dout), .wr_ack(d8_ack), .overflow(d8_ovf),
        .underflow(d8_udf), .full(d8_full), .empty(d8_empty), .almostfull(d8_af),
        .almostempty(d8_ae), .count(d8_cnt)
    );

    fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(6)) u_d6 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .data_out(d6_dout), .wr_ack(d6_ack), .overflow(d6_ovf),
        .underflow(d6_udf), .full(d6_full), .empty(d6_empty), .almostfull(d6_af),
        .almostempty(d6_ae), .count(d6_cnt)
    );

    fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1'b1)) u_fw (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .data_out(fw_dout), .wr_ack(fw_ack), .overflow(fw_ovf),
        .underflow(fw_udf), .full(fw_full), .empty(fw_empty), .almostfull(fw_af),
        .almostempty(fw_ae), .count(fw_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given request; outputs are sampled 1 time unit after the edge
    task automatic cyc(input logic w, input logic r, input logic [15:0] d, input logic c);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        clr     = c;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_count", d8_cnt, 0);
        chk("rst_empty", d8_empty, 1);
        chk("rst_full", d8_full, 0);
        chk("rst_af", d8_af, 0);
        chk("rst_ae", d8_ae, 0);
        chk("rst_ack", d8_ack, 0);
        chk("rst_ovf", d8_ovf, 0);
        chk("rst_udf", d8_udf, 0);
        chk("rst_dout", d8_dout, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: fill with 0x0001..0x0009
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b1, 1'b0, 16'(i), 1'b0);
            if (i <= 8) begin
                chk($sformatf("fill%0d_ack", i), d8_ack, 1);
                chk($sformatf("fill%0d_cnt", i), d8_cnt, i);
                chk($sformatf("fill%0d_af", i), d8_af, (i == 7) ? 1 : 0);
                chk($sformatf("fill%0d_ae", i), d8_ae, (i == 1) ? 1 : 0);
                chk($sformatf("fill%0d_full", i), d8_full, (i == 8) ? 1 : 0);
                chk($sformatf("fill%0d_ovf", i), d8_ovf, 0);
            end else begin
                chk("fill9_ovf", d8_ovf, 1);
                chk("fill9_ack", d8_ack, 0);
                chk("fill9_cnt", d8_cnt, 8);
                chk("fill9_full", d8_full, 1);
            end
        end

        // 2: drain 9 times
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b0, 1'b1, 16'h0000, 1'b0);
            if (i <= 8) begin
                chk($sformatf("drain%0d_dout", i), d8_dout, i);
                chk($sformatf("drain%0d_cnt", i), d8_cnt, 8 - i);
                chk($sformatf("drain%0d_udf", i), d8_udf, 0);
            end else begin
                chk("drain9_udf", d8_udf, 1);
                chk("drain9_empty", d8_empty, 1);
                chk("drain9_dout", d8_dout, 16'h0008);
            end
        end

        // 3: simultaneous requests on empty, then on full
        cyc(1'b1, 1'b1, 16'h0030, 1'b0);
        chk("sim_empty_cnt", d8_cnt, 1);
        chk("sim_empty_ack", d8_ack, 1);
        chk("sim_empty_dout", d8_dout, 16'h0008);
        for (int i = 1; i <= 7; i++) cyc(1'b1, 1'b0, 16'(16'h0030 + i), 1'b0);
        chk("sim_fill_cnt", d8_cnt, 8);
        chk("sim_fill_full", d8_full, 1);
        cyc(1'b1, 1'b1, 16'h0099, 1'b0);
        chk("sim_full_cnt", d8_cnt, 7);
        chk("sim_full_ack", d8_ack, 0);
        chk("sim_full_dout", d8_dout, 16'h0030);
        chk("sim_full_full", d8_full, 0);
        for (int i = 1; i <= 7; i++) begin
            cyc(1'b0, 1'b1, 16'h0000, 1'b0);
            chk($sformatf("sim_drain%0d", i), d8_dout, 16'h0030 + i);
        end
        chk("sim_drain_cnt", d8_cnt, 0);

        // 4: wrap on depth 8
        for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 16'(16'h0010 + i), 1'b0);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b1, 16'h0000, 1'b0);
            chk($sformatf("wrap8_pre%0d", i), d8_dout, 16'h0010 + i);
        end
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 16'(16'h0100 + i), 1'b0);
        chk("wrap8_cnt", d8_cnt, 8);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 16'h0000, 1'b0);
            chk($sformatf("wrap8_rd%0d", i), d8_dout, 16'h0100 + i);
        end
        chk("wrap8_empty", d8_empty, 1);

        // 4: wrap on depth 6
        do_reset();
        for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, 16'(16'h0010 + i), 1'b0);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b1, 16'h0000, 1'b0);
            chk($sformatf("wrap6_pre%0d", i), d6_dout, 16'h0010 + i);
        end
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 16'(16'h0100 + i), 1'b0);
        chk("wrap6_cnt", d6_cnt, 6);
        chk("wrap6_full", d6_full, 1);
        cyc(1'b1, 1'b0, 16'h0EEE, 1'b0);
        chk("wrap6_ovf", d6_ovf, 1);
        chk("wrap6_ovf_cnt", d6_cnt, 6);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, 16'h0000, 1'b0);
            chk($sformatf("wrap6_rd%0d", i), d6_dout, 16'h0100 + i);
        end
        chk("wrap6_empty", d6_empty, 1);

        // 5: reset in the middle of operation
        do_reset();
        for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 16'(16'h0500 + i), 1'b0);
        cyc(1'b0, 1'b1, 16'h0000, 1'b0);
        chk("mid_pre_dout", d8_dout, 16'h0501);
        chk("mid_pre_cnt", d8_cnt, 4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt", d8_cnt, 0);
        chk("mid_rst_empty", d8_empty, 1);
        chk("mid_rst_dout", d8_dout, 16'h0000);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 16'hA5A5, 1'b0);
        chk("mid_wr_cnt", d8_cnt, 1);
        cyc(1'b0, 1'b1, 16'h0000, 1'b0);
        chk("mid_rd_dout", d8_dout, 16'hA5A5);
        chk("mid_rd_cnt", d8_cnt, 0);

        // 6: FWFT and flush
        do_reset();
        chk("fw_empty_dout", fw_dout, 16'h0000);
        cyc(1'b1, 1'b0, 16'h1234, 1'b0);
        chk("fw_first_dout", fw_dout, 16'h1234);
        chk("fw_first_cnt", fw_cnt, 1);
        cyc(1'b1, 1'b0, 16'h2222, 1'b0);
        cyc(1'b1, 1'b0, 16'h3333, 1'b0);
        cyc(1'b1, 1'b0, 16'h4444, 1'b0);
        chk("fw_head_dout", fw_dout, 16'h1234);
        chk("fw_head_cnt", fw_cnt, 4);
        cyc(1'b0, 1'b1, 16'h0000, 1'b0);
        chk("fw_pop_dout", fw_dout, 16'h2222);
        chk("fw_pop_cnt", fw_cnt, 3);
        cyc(1'b1, 1'b1, 16'h7777, 1'b1);
        chk("fw_clr_cnt", fw_cnt, 0);
        chk("fw_clr_empty", fw_empty, 1);
        chk("fw_clr_dout", fw_dout, 16'h0000);
        chk("fw_clr_ack", fw_ack, 0);
        chk("fw_clr_udf", fw_udf, 0);
        chk("d8_clr_dout", d8_dout, 16'h0000);
        cyc(1'b1, 1'b0, 16'hBEEF, 1'b0);
        chk("fw_after_clr_dout", fw_dout, 16'hBEEF);
        cyc(1'b0, 1'b1, 16'h0000, 1'b0);
        chk("fw_last_pop_dout", fw_dout, 16'h0000);
        chk("fw_last_pop_empty", fw_empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
